// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_pkg
// Description : Shared definitions for the instruction-fetch stage: FSM
//               state encoding, the all-zero word, the stall-vector bit
//               owned by the fetch stage and the sequential-PC helper.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_pkg;

    // Fetch FSM states. DRAIN waits out a request whose data is unwanted.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HAVE  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Bit of the pipeline stall vector that freezes the fetch stage.
    localparam int unsigned c_stall_if_bit = 0;

    localparam logic [31:0] c_inst_bytes = 32'd4;

    // Next sequential fetch address; wraps naturally modulo 2^32.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + c_inst_bytes;
    endfunction

endpackage : inst_fetch_pkg
`default_nettype wire

// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_if
// Description : Instruction-memory request bus between the fetch stage
//               (master) and the instruction memory (slave).
//   req   : request valid, held until ack
//   addr  : word address of the request, stable while req is high
//   ack   : one-cycle completion pulse
//   rdata : instruction word, valid with ack
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface : inst_fetch_if
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Instruction-fetch stage. Holds the PC, issues one request at
//               a time to instruction memory, presents the fetched pair to
//               the IF/ID register and follows branch / exception redirects.
// Ports       :
//   clk, rst          : clock, asynchronous active-high reset
//   stall[5:0]        : pipeline stall vector, bit 0 holds this stage
//   branch_flag_i     : taken-branch redirect from decode
//   branch_target_i   : branch target address
//   flush_i, new_pc_i : exception redirect (highest priority)
//   imem (master)     : instruction-memory request bus
//   if_pc, if_inst    : fetched PC / instruction to IF/ID
//   stallreq_if       : high while no valid instruction is held
//   excp_adel         : misaligned fetch address flag
// Configuration :
//   INST_FETCH_ALIGN_CHK_EN - when defined, a misaligned target is not
//   requested; a nop is presented with excp_adel set until the next flush.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         stall,
    input  logic               branch_flag_i,
    input  logic [31:0]        branch_target_i,
    input  logic               flush_i,
    input  logic [31:0]        new_pc_i,
    inst_fetch_if.master       imem,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_inst,
    output logic               stallreq_if,
    output logic               excp_adel
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    logic [31:0] r_pc;        // address of the current / last request
    logic [31:0] r_drain_pc;  // redirect target remembered while draining
    logic [31:0] r_if_pc;
    logic [31:0] r_if_inst;

    logic [31:0] w_target;
    logic        w_redirect;
    logic        w_capture;
    logic        w_drain_load;
    logic        w_misalign;
    logic        w_hold_excp;
    logic        w_req;

    // Only bit 0 of the stall vector belongs to this stage.
    logic        w_unused_stall;
    assign w_unused_stall = &{1'b0, stall[5:1]};

    // ------------------------------------------------------------------
    // Next-state logic. Every path that starts a new fetch goes through
    // w_redirect/w_target so the alignment check sits in one place.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_redirect   = 1'b0;
        w_target     = r_pc;
        w_capture    = 1'b0;
        w_drain_load = 1'b0;
        w_misalign   = 1'b0;

        case (r_state)
            IDLE: begin
                w_redirect = 1'b1;
                w_target   = flush_i ? new_pc_i : RESET_PC;
            end
            REQ: begin
                if (imem.ack) begin
                    if (flush_i) begin
                        // Data belongs to the flushed path: drop it.
                        w_redirect = 1'b1;
                        w_target   = new_pc_i;
                    end else begin
                        w_capture    = 1'b1;
                        w_next_state = HAVE;
                    end
                end else if (flush_i) begin
                    // The bus request cannot be withdrawn; wait it out.
                    w_drain_load = 1'b1;
                    w_next_state = DRAIN;
                end
            end
            HAVE: begin
                if (flush_i) begin
                    w_redirect = 1'b1;
                    w_target   = new_pc_i;
                end else if (!w_hold_excp && !stall[c_stall_if_bit]) begin
                    w_redirect = 1'b1;
                    w_target   = branch_flag_i ? branch_target_i : seq_pc(r_pc);
                end
            end
            DRAIN: begin
                if (imem.ack) begin
                    w_redirect = 1'b1;
                    w_target   = flush_i ? new_pc_i : r_drain_pc;
                end else if (flush_i) begin
                    w_drain_load = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

`ifdef INST_FETCH_ALIGN_CHK_EN
        w_misalign = w_redirect && (w_target[1:0] != 2'b00);
`else
        w_misalign = 1'b0;
`endif

        if (w_redirect) begin
            w_next_state = w_misalign ? HAVE : REQ;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_drain_pc <= ZeroWord;
            r_if_pc    <= ZeroWord;
            r_if_inst  <= ZeroWord;
        end else begin
            if (w_redirect) begin
                r_pc <= w_target;
            end
            if (w_drain_load) begin
                r_drain_pc <= new_pc_i;
            end
            if (w_capture) begin
                r_if_pc   <= r_pc;
                r_if_inst <= imem.rdata;
            end else if (w_misalign) begin
                // Misaligned target: present a nop at the faulting PC.
                r_if_pc   <= w_target;
                r_if_inst <= ZeroWord;
            end
        end
    end

`ifdef INST_FETCH_ALIGN_CHK_EN
    logic r_excp_adel;

    // Set when entering HAVE on a misaligned target; any later redirect
    // (only a flush can happen while it is set) re-evaluates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_excp_adel <= 1'b0;
        end else if (w_redirect) begin
            r_excp_adel <= w_misalign;
        end
    end

    assign w_hold_excp = r_excp_adel;
    assign excp_adel   = r_excp_adel;
`else
    assign w_hold_excp = 1'b0;
    assign excp_adel   = 1'b0;
`endif

    // All outputs decode from registered state only.
    assign w_req       = (r_state == REQ) || (r_state == DRAIN);
    assign imem.req    = w_req;
    assign imem.addr   = w_req ? r_pc : ZeroWord;
    assign stallreq_if = (r_state != HAVE);
    assign if_pc       = r_if_pc;
    assign if_inst     = r_if_inst;

endmodule : inst_fetch
`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-004 stall  in  6  SHALL be the pipeline stall vector; stall[0]=1 holds the fetch stage.
REQ-005 branch_flag_i  in  1 / branch_target_i  in  32  SHALL be the redirect from decode.
REQ-006 flush_i  in  1 / new_pc_i  in  32  SHALL be the exception redirect (highest priority).
REQ-007 imem_req  out  1 / imem_addr  out  32  SHALL be the instruction-memory request and word address.
REQ-008 imem_ack  in  1 / imem_rdata  in  32  SHALL be the one-cycle completion pulse and its data.
REQ-009 if_pc  out  32 / if_inst  out  32  SHALL be the fetched pair presented to the IF/ID register.
REQ-010 stallreq_if  out  1  SHALL request a pipeline stall while no valid instruction is held.
REQ-011 excp_adel  out  1  SHALL flag a misaligned fetch address.

Function
REQ-012 The FSM SHALL have states IDLE, REQ, HAVE, DRAIN.
REQ-013 IDLE: exits to REQ on the first edge after reset release, with pc=RESET_PC.
REQ-014 REQ: imem_req=1; imem_addr=pc held stable until imem_ack; on ack, capture if_inst=imem_rdata and if_pc=pc; go to HAVE.
REQ-015 HAVE: imem_req=0; if_pc/if_inst held; if stall[0]=1, remain.
REQ-016 HAVE with stall[0]=0: next pc=branch_flag_i ? branch_target_i : pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0); go to REQ.
REQ-017 branch_flag_i SHALL be ignored outside the HAVE-advance edge.
REQ-018 flush_i in HAVE or IDLE: pc=new_pc_i; go to REQ next edge.
REQ-019 flush_i in REQ without ack: latch new_pc_i; go to DRAIN; imem_req stays 1 with the old address until ack.
REQ-020 flush_i in REQ on the ack edge: discard imem_rdata; go to REQ at new_pc_i.
REQ-021 DRAIN: on ack, discard imem_rdata and go to REQ at the latched pc. A further flush_i overwrites the latched pc.
REQ-022 stallreq_if SHALL be 1 in IDLE, REQ and DRAIN; it SHALL be 0 in HAVE (registered, no combinational path from imem_ack).
REQ-023 imem_ack SHALL be ignored in IDLE and HAVE.
REQ-024 Throughput SHALL be one instruction per (memory latency + 1) cycles minimum.

Reset
REQ-025 While rst=1: state=IDLE; pc=RESET_PC; if_pc=0; if_inst=0; imem_req=0; imem_addr=0; stallreq_if=1; excp_adel=0.
REQ-026 Reset asserted mid-REQ SHALL abandon the transaction immediately. An ack arriving after reset release in IDLE SHALL be ignored.

Configuration
REQ-027 Macro INST_FETCH_ALIGN_CHK_EN defined: a target pc with pc[1:0]!=0 SHALL NOT issue a request.
- Instead, the FSM enters HAVE with if_inst=0 (nop), if_pc=pc and excp_adel=1.
- It holds there, ignoring advance, until flush_i.
- excp_adel clears on flush.
REQ-028 Macro undefined: no check; imem_addr=pc unchanged; excp_adel tied 0.

Structure
REQ-029 The state encodings, ZeroWord and the stall bit index SHALL live in the shared defines package.
REQ-030 No sub-module; pc and FSM in one module.

Verification
REQ-031 Reset release with ack returning after 2 wait cycles -> imem_addr=0 until ack; then if_pc=0, if_inst=rdata; stallreq_if 1 for 4 cycles, then 0.
REQ-032 HAVE at pc=0x100 with stall[0]=1 for 3 cycles -> outputs frozen, imem_req=0. Release -> imem_addr=0x104.
REQ-033 HAVE at 0x200 with branch_flag_i=1, target=0x400, stall[0]=0 -> next imem_addr=0x400. branch_flag_i asserted during REQ -> no effect.
REQ-034 flush_i with new_pc_i=0x180 during an unacked REQ at 0x300 -> addr stays 0x300 until ack; data discarded; next request at 0x180; if_inst never shows the 0x300 data.
REQ-035 pc=0xFFFF_FFFC advance -> imem_addr=0x0000_0000.
REQ-036 With INST_FETCH_ALIGN_CHK_EN, branch target 0x202 -> no imem_req; excp_adel=1, if_inst=0. flush_i to 0x180 -> excp_adel=0, request at 0x180.
